// File: rtl/acc_buf.sv
// Accumulation buffer: per-lane masked read-modify-write of BATCH signed partial sums
// through a two-stage pipeline with forwarding, plus a drain port with optional clear.
module acc_buf #(
  parameter int ADDR_W = 8,
  parameter int BATCH  = 32,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     acc_addr,
  input  logic [BATCH-1:0]      acc_en,
  input  logic                  acc_new,
  input  logic [BATCH*DW-1:0]   acc_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_clr,
  output logic [BATCH*DW-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  rd_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int RW    = BATCH * DW;

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = s[DW-1:0];
  endfunction

  logic [RW-1:0]     mem_q [DEPTH];

  logic              vld_p1_q, vld_p2_q, vld_p3_q;
  logic [ADDR_W-1:0] addr_p1_q, addr_p2_q, addr_p3_q;
  logic [BATCH-1:0]  en_p1_q, en_p2_q, en_p3_q;
  logic              new_p1_q;
  logic [RW-1:0]     data_p1_q, ram_p1_q, res_p1_d, res_p2_q, res_p3_q;

  logic              clr_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              rd_valid_q, rd_err_q;
  logic [RW-1:0]     rd_data_q, rd_data_d;
  logic              busy_d, rd_accept;

  assign busy_d    = (|acc_en) | vld_p1_q | vld_p2_q;
  assign rd_accept = rd_en & ~busy_d;
  // A drain on the edge that writes a pending clear to the same row must see zeros.
  assign rd_data_d = (clr_q && (clr_addr_q == rd_addr)) ? '0 : mem_q[rd_addr];

  assign busy     = busy_d;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

  // ---- S1: forward youngest older per-lane value, then add or overwrite ----
  always_comb begin
    logic signed [DW-1:0] old_v;
    logic signed [DW-1:0] add_v;
    old_v    = '0;
    add_v    = '0;
    res_p1_d = '0;
    for (int i = 0; i < BATCH; i++) begin
      old_v = ram_p1_q[i*DW +: DW];
      if (vld_p3_q && (addr_p3_q == addr_p1_q) && en_p3_q[i])
        old_v = res_p3_q[i*DW +: DW];
      if (vld_p2_q && (addr_p2_q == addr_p1_q) && en_p2_q[i])
        old_v = res_p2_q[i*DW +: DW];
      add_v = data_p1_q[i*DW +: DW];
      res_p1_d[i*DW +: DW] = new_p1_q ? add_v : sat_add(old_v, add_v);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      clr_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_p1_q   <= |acc_en;
      vld_p2_q   <= vld_p1_q;
      vld_p3_q   <= vld_p2_q | clr_q;
      clr_q      <= rd_accept & rd_clr;
      rd_valid_q <= rd_accept;
      if (rd_en && busy_d)
        rd_err_q <= 1'b1;
      if (rd_accept)
        rd_data_q <= rd_data_d;
    end
  end

  // ---- S0 -> S1 capture, S1 -> S2 result, S2 -> write-in-flight record ----
  always_ff @(posedge clk) begin
    addr_p1_q  <= acc_addr;
    en_p1_q    <= acc_en;
    new_p1_q   <= acc_new;
    data_p1_q  <= acc_data;
    ram_p1_q   <= mem_q[acc_addr];
    addr_p2_q  <= addr_p1_q;
    en_p2_q    <= en_p1_q;
    res_p2_q   <= res_p1_d;
    clr_addr_q <= rd_addr;
    // The write performed on this edge is remembered so S1 can forward it next cycle.
    if (vld_p2_q) begin
      addr_p3_q <= addr_p2_q;
      en_p3_q   <= en_p2_q;
      res_p3_q  <= res_p2_q;
    end else begin
      addr_p3_q <= clr_addr_q;
      en_p3_q   <= '1;
      res_p3_q  <= '0;
    end
  end

  // ---- S2: RAM write (accumulate result or drain clear, never both) ----
  always_ff @(posedge clk) begin
    if (vld_p2_q) begin
      for (int i = 0; i < BATCH; i++)
        if (en_p2_q[i])
          mem_q[addr_p2_q][i*DW +: DW] <= res_p2_q[i*DW +: DW];
    end else if (clr_q) begin
      mem_q[clr_addr_q] <= '0;
    end
  end

endmodule
